aes_key_sched_ctrl: RTL and testbench

Round-key sequencer for the AES-128 core. It drives an external single-round key-expansion step unit for 10 cycles to build all 11 round keys from a loaded cipher key, stores them, and streams them to the cipher datapath over a valid/ready handshake. Keys stream in forward order (round 0→10) for encryption or reverse order (10→0) for decryption. This removes per-block re-expansion from the inverse cipher path.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_rk_buffer.sv | 38 +++
 rtl/aes_key_sched_ctrl.sv | 156 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants: state enum, round/width constants,
// initial round constant and the GF(2^8) xtime helper.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_RK_W  = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StReady,
        StStream
    } key_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rk_buffer.sv
// Round-key register file: one write port, one combinational read port.
// With AES_KEY_ZEROIZE_EN defined, a synchronous active-low reset clears every entry.
module aes_rk_buffer
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = AES_NR + 1,
    parameter int unsigned W     = AES_RK_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic          reset,
`endif
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else
`endif
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key sequencer: drives an external step unit to expand a cipher key into
// NR+1 stored round keys, then streams them forward or reverse. Option: AES_KEY_ZEROIZE_EN.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_load,
    input  logic [AES_RK_W-1:0] key_in,
    output logic                key_busy,
    output logic                key_ready,
    output logic [AES_RK_W-1:0] exp_key_out,
    output logic [7:0]          exp_rcon,
    input  logic [AES_RK_W-1:0] exp_key_in,
    input  logic                rk_start,
    input  logic                rk_dir,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [AES_RK_W-1:0] rk_data,
    output logic [3:0]          rk_index,
    output logic                rk_last
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    key_state_e          state;
    logic [AES_RK_W-1:0] cur;
    logic [7:0]          rcon;
    logic [3:0]          cnt;
    logic [3:0]          idx;
    logic                dir;

    logic                load_acc;
    logic                expanding;
    logic [3:0]          idx_nxt;
    logic [3:0]          idx_term;
    logic                buf_we;
    logic [3:0]          buf_waddr;
    logic [AES_RK_W-1:0] buf_wdata;
    logic [AES_RK_W-1:0] buf_rdata;

    assign load_acc  = key_load && (state == StIdle || state == StReady);
    assign expanding = (state == StExpand);
    assign idx_nxt   = dir ? idx - 4'd1 : idx + 4'd1;
    assign idx_term  = dir ? 4'd0 : LAST_IDX;

    // Entry 0 is the cipher key itself; entries 1..NR come from the step unit.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = cnt;
        buf_wdata = exp_key_in;
        if (reset && load_acc) begin
            buf_we    = 1'b1;
            buf_waddr = 4'd0;
            buf_wdata = key_in;
        end else if (reset && expanding) begin
            buf_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            key_busy  <= 1'b0;
            key_ready <= 1'b0;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            idx       <= 4'd0;
            rcon      <= 8'h00;
            cnt       <= 4'd0;
            dir       <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StReady: begin
                    if (key_load) begin
                        cnt       <= 4'd1;
                        rcon      <= RCON_INIT;
                        key_busy  <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= StExpand;
                    end else if (state == StReady && rk_start) begin
                        idx      <= rk_dir ? LAST_IDX : 4'd0;
                        dir      <= rk_dir;
                        rk_valid <= 1'b1;
                        rk_last  <= 1'b0;
                        state    <= StStream;
                    end
                end
                StExpand: begin
                    rcon <= xtime(rcon);
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST_IDX) begin
                        key_busy  <= 1'b0;
                        key_ready <= 1'b1;
                        state     <= StReady;
                    end
                end
                StStream: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            state    <= StReady;
                        end else begin
                            idx     <= idx_nxt;
                            rk_last <= (idx_nxt == idx_term);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
        if (!reset) begin
            cur <= '0;
        end else
`endif
        if (load_acc) begin
            cur <= key_in;
        end else if (expanding) begin
            cur <= exp_key_in;
        end
    end

    aes_rk_buffer #(
        .DEPTH (NR + 1),
        .W     (AES_RK_W),
        .AW    (4)
    ) u_rk_buffer (
        .clk   (clk),
`ifdef AES_KEY_ZEROIZE_EN
        .reset (reset),
`endif
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (idx),
        .rdata (buf_rdata)
    );

    assign exp_key_out = cur;
    assign exp_rcon    = rcon;
    assign rk_index    = idx;

`ifdef AES_KEY_ZEROIZE_EN
    assign rk_data = rk_valid ? buf_rdata : '0;
`else
    assign rk_data = buf_rdata;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl using the FIPS-197 AES-128 key schedule;
// the external step unit is modelled by a lookup of the published round keys.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] RK_TAB [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [7:0] RCON_TAB [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };
    localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   idx;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_busy;
    logic         key_ready;
    logic [127:0] exp_key_out;
    logic [7:0]   exp_rcon;
    logic [127:0] exp_key_in;
    logic         rk_start;
    logic         rk_dir;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;

    beat_t q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .key_load    (key_load),
        .key_in      (key_in),
        .key_busy    (key_busy),
        .key_ready   (key_ready),
        .exp_key_out (exp_key_out),
        .exp_rcon    (exp_rcon),
        .exp_key_in  (exp_key_in),
        .rk_start    (rk_start),
        .rk_dir      (rk_dir),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_index    (rk_index),
        .rk_last     (rk_last)
    );

    // Step unit: known FIPS round key + matching rcon yields the next round key.
    always_comb begin
        exp_key_in = {exp_key_out[119:0], exp_key_out[127:120]} ^ {120'h0, exp_rcon};
        for (int i = 0; i < 10; i++) begin
            if (exp_key_out == RK_TAB[i] && exp_rcon == RCON_TAB[i]) begin
                exp_key_in = RK_TAB[i+1];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && rk_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: rk_valid=1 index=%0d, expected no beat", rk_index);
            end else begin
                chk("rk_data", rk_data, q[0].data);
                chk("rk_index", 128'(rk_index), 128'(q[0].idx));
                chk("rk_last", 128'(rk_last), 128'(q[0].last));
                if (rk_ready) void'(q.pop_front());
            end
        end
`ifdef AES_KEY_ZEROIZE_EN
        else if (reset === 1'b1) begin
            chk("rk_data_idle_zero", rk_data, 128'h0);
        end
`endif
    end

    // Load the FIPS key and track the expansion; optionally collide with a second load
    // mid-expansion or issue rk_start together with the load.
    task automatic load_key(input logic inject, input logic start_too);
        key_load = 1'b1;
        key_in   = RK_TAB[0];
        rk_start = start_too;
        tick();
        key_load = 1'b0;
        rk_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("exp_busy", 128'(key_busy), 128'(1'b1));
            chk("exp_ready_low", 128'(key_ready), 128'(1'b0));
            chk("exp_rcon", 128'(exp_rcon), 128'(RCON_TAB[i]));
            chk("exp_key_out", exp_key_out, RK_TAB[i]);
            if (start_too) chk("exp_no_valid", 128'(rk_valid), 128'(1'b0));
            key_load = inject && (i == 3);
            key_in   = KEY_ALT;
            rk_start = inject && (i == 5);
            tick();
            key_load = 1'b0;
            rk_start = 1'b0;
        end
        chk("ready_after_10", 128'(key_ready), 128'(1'b1));
        chk("busy_after_10", 128'(key_busy), 128'(1'b0));
    endtask

    // mode 0: rk_ready held high; mode 1: rk_ready pattern 1,0,0,1,0,0,...
    task automatic stream(input logic dir, input int mode, input logic inject);
        int c;
        for (int i = 0; i <= 10; i++) begin
            beat_t b;
            b.data = RK_TAB[dir ? 10 - i : i];
            b.idx  = 4'(dir ? 10 - i : i);
            b.last = (i == 10);
            q.push_back(b);
        end
        rk_start = 1'b1;
        rk_dir   = dir;
        tick();
        rk_start = 1'b0;
        rk_dir   = ~dir;
        chk("valid_after_start", 128'(rk_valid), 128'(1'b1));
        c = 0;
        while (q.size() > 0 && c < 100) begin
            rk_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            key_load = inject && (c == 2);
            key_in   = KEY_ALT;
            tick();
            c++;
        end
        rk_ready = 1'b0;
        key_load = 1'b0;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL stream_timeout: %0d beats outstanding, expected 0", q.size());
            q.delete();
        end
        if (mode == 0) chk("stream_cycles", 128'(c), 128'(11));
        chk("valid_after_stream", 128'(rk_valid), 128'(1'b0));
        chk("ready_after_stream", 128'(key_ready), 128'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        rk_start = 1'b0;
        rk_dir   = 1'b0;
        rk_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 128'(key_busy), 128'(1'b0));
        chk("rst_ready", 128'(key_ready), 128'(1'b0));
        chk("rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("rst_last", 128'(rk_last), 128'(1'b0));
        chk("rst_index", 128'(rk_index), 128'(0));
        chk("rst_rcon", 128'(exp_rcon), 128'(0));
`ifdef AES_KEY_ZEROIZE_EN
        chk("rst_rk_data_zero", rk_data, 128'h0);
        chk("rst_cur_zero", exp_key_out, 128'h0);
`endif
        reset = 1'b1;

        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        chk("idle_start_ignored", 128'(rk_valid), 128'(1'b0));

        load_key(1'b0, 1'b0);
        stream(1'b1, 0, 1'b0);
        stream(1'b0, 1, 1'b0);

        load_key(1'b1, 1'b0);
        stream(1'b0, 0, 1'b1);
        stream(1'b1, 0, 1'b0);

        load_key(1'b0, 1'b1);
        stream(1'b0, 0, 1'b0);

        key_load = 1'b1;
        key_in   = RK_TAB[0];
        tick();
        key_load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_ready", 128'(key_ready), 128'(1'b0));
        chk("midrst_busy", 128'(key_busy), 128'(1'b0));
        chk("midrst_rcon", 128'(exp_rcon), 128'(0));
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        chk("midrst_start_ignored", 128'(rk_valid), 128'(1'b0));
        tick();
        chk("midrst_still_idle", 128'(rk_valid), 128'(1'b0));
        load_key(1'b0, 1'b0);
        stream(1'b1, 0, 1'b0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
